// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare/shift ops plus an
// iterative unsigned multiply/divide engine that writes the Hi/Lo pair.
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             md_done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [5:0] FnAnd   = 6'd36;
    localparam logic [5:0] FnOr    = 6'd37;
    localparam logic [5:0] FnAdd   = 6'd32;
    localparam logic [5:0] FnSub   = 6'd34;
    localparam logic [5:0] FnSlt   = 6'd42;
    localparam logic [5:0] FnSll   = 6'd0;
    localparam logic [5:0] FnSrl   = 6'd2;
    localparam logic [5:0] FnMultu = 6'd25;
    localparam logic [5:0] FnDivu  = 6'd27;
    localparam logic [5:0] FnMfhi  = 6'd16;
    localparam logic [5:0] FnMflo  = 6'd18;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t               stateQ, stateD;
    logic [2*WIDTH-1:0]   accQ;
    logic [WIDTH-1:0]     opBQ;
    logic [SHW-1:0]       cntQ;
    logic                 bZeroQ;

    logic                 accept;
    logic                 isMd;
    logic                 lastStep;
    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH-1:0]   mulNext;
    logic [WIDTH:0]       divShift;
    logic [WIDTH:0]       divDiff;
    logic [2*WIDTH-1:0]   divNext;
    logic [2*WIDTH-1:0]   accNext;
    logic [WIDTH-1:0]     aluRes;

    assign busy     = (stateQ != IDLE);
    assign ready    = ~busy;
    assign accept   = valid_in & ready;
    assign isMd     = (funct == FnMultu) || (funct == FnDivu);
    assign lastStep = (cntQ == SHW'(WIDTH - 1));

    // Multiply: acc = {partial, multiplier}; add B on the multiplier LSB, shift right.
    assign mulSum  = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, opBQ} : '0);
    assign mulNext = {mulSum, accQ[WIDTH-1:1]};

    // Divide: acc = {remainder, quotient}; quotient shifts in one result bit per step.
    // With B=0 every trial subtract succeeds, giving rem=A and quotient all ones.
    assign divShift = accQ[2*WIDTH-1:WIDTH-1];
    assign divDiff  = divShift - {1'b0, opBQ};
    assign divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], accQ[WIDTH-2:0], 1'b0}
                                     : {divDiff[WIDTH-1:0],  accQ[WIDTH-2:0], 1'b1};

    assign accNext = (stateQ == MUL) ? mulNext : divNext;

    always_comb begin
        aluRes = '0;
        case (funct)
            FnAnd:  aluRes = data_a & data_b;
            FnOr:   aluRes = data_a | data_b;
            FnAdd:  aluRes = data_a + data_b;
            FnSub:  aluRes = data_a - data_b;
            FnSlt:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
            FnSll:  aluRes = data_a << data_b[SHW-1:0];
            FnSrl:  aluRes = data_a >> data_b[SHW-1:0];
            FnMfhi: aluRes = hi;
            FnMflo: aluRes = lo;
            default: aluRes = '0;
        endcase
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (accept && funct == FnMultu) stateD = MUL;
                else if (accept && funct == FnDivu) stateD = DIV;
            end
            MUL, DIV: if (lastStep) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ       <= IDLE;
            accQ         <= '0;
            opBQ         <= '0;
            cntQ         <= '0;
            bZeroQ       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            md_done      <= 1'b0;
            div_by_zero  <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            stateQ       <= stateD;
            result_valid <= 1'b0;
            md_done      <= 1'b0;
            div_by_zero  <= 1'b0;
            if (stateQ == IDLE) begin
                if (accept && isMd) begin
                    accQ   <= {{WIDTH{1'b0}}, data_a};
                    opBQ   <= data_b;
                    cntQ   <= '0;
                    bZeroQ <= (funct == FnDivu) && (data_b == '0);
                end else if (accept) begin
                    result       <= aluRes;
                    result_valid <= 1'b1;
                end
            end else begin
                accQ <= accNext;
                cntQ <= cntQ + 1'b1;
                if (lastStep) begin
                    hi          <= accNext[2*WIDTH-1:WIDTH];
                    lo          <= accNext[WIDTH-1:0];
                    md_done     <= 1'b1;
                    div_by_zero <= bZeroQ;
                end
            end
        end
    end
endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Parametrised successor to the 32-bit execute-stage ALU.
- Covers single-cycle logic, arithmetic, compare and shift ops, plus an iterative unsigned multiply/divide engine that writes a Hi/Lo register pair.
- Adds a ready/valid handshake, DIVU, SRL, configurable datapath width and a divide-by-zero flag.
- Sits in the EX stage; the pipeline stalls on ~ready.

Parameters:
- WIDTH, 32: datapath width in bits; must be a power of two, >= 8.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- valid_in  in  1  operation request.
- funct  in  6  operation code: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SLL=0, SRL=2, MULTU=25, DIVU=27, MFHI=16, MFLO=18.
- data_a  in  WIDTH  operand A (shift source for SLL/SRL).
- data_b  in  WIDTH  operand B (shift amount = data_b[SHW-1:0]).
- ready  out  1  equals ~busy; request accepted when valid_in & ready.
- busy  out  1  multiply/divide iteration in progress.
- result  out  WIDTH  registered single-cycle result.
- result_valid  out  1  one-cycle pulse; result is updated.
- md_done  out  1  one-cycle pulse; Hi/Lo just written.
- div_by_zero  out  1  pulses with md_done when the finished op was DIVU with B=0.
- hi  out  WIDTH  Hi register.
- lo  out  WIDTH  Lo register.

Behaviour:
- Reset (rst=0, async): result, hi and lo go to 0. busy, result_valid, md_done and div_by_zero go to 0. FSM goes to IDLE and the iteration counter to 0. Applies mid-operation: the in-flight op is discarded and no md_done is issued.
- Accept: valid_in & ready at a rising edge. valid_in while busy is ignored; the requester holds it.
- Single-cycle ops (latency 1): result and result_valid are registered at the accepting edge.
  - ADD/SUB: modulo 2^WIDTH, no overflow flag.
  - SLT: signed compare; result is 1 or 0.
  - SLL/SRL: logical shift by data_b[SHW-1:0].
  - MFHI/MFLO: return hi/lo.
  - Unknown funct: result=0, result_valid still pulses.
  - result holds its value between pulses.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on accepted MULTU; IDLE -> DIV on accepted DIVU.
  - Operands are latched and the counter cleared on entry. result_valid stays 0 for MULTU/DIVU.
- MUL: one shift-add step per cycle (2*WIDTH-bit product register).
- DIV: one restoring shift-subtract step per cycle.
- Timing: busy=1 for exactly WIDTH cycles after the accepting edge. On the WIDTH-th step edge:
  - hi/lo are written (MULTU: hi=product[2W-1:W], lo=product[W-1:0]; DIVU: hi=remainder, lo=quotient);
  - busy drops; md_done=1 for the following cycle.
  - A new request may be accepted on that same following edge.
- DIVU with B=0: still takes WIDTH cycles. Result is hi=A, lo=all ones, and div_by_zero pulses with md_done.
- MFHI/MFLO cannot issue while busy (ready=0). They therefore always observe the completed Hi/Lo.
- hi/lo change only on multiply/divide completion or reset.

Test Plan:
- WIDTH=32: ADD 0xFFFFFFFF+1 -> result=0, result_valid 1 cycle after accept. SUB 5-7 -> 0xFFFFFFFE. SLT -1,1 -> 1. SLT 1,-1 -> 0.
- SLL 0x1 by data_b=0x21 -> 0x2 (amount uses 5 LSBs only). SRL 0x80000000 by 31 -> 1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, md_done one pulse. MFHI then returns 0xFFFFFFFE.
- DIVU 100/7 -> lo=14, hi=2. DIVU 9/0 -> hi=9, lo=0xFFFFFFFF, div_by_zero pulse. ADD requested while busy -> ignored until ready=1, then accepted.
- Drop rst to 0 at cycle 10 of a MULTU -> hi=lo=0, busy=0, no md_done. After release, a new MULTU 3*4 -> lo=12, hi=0.
- WIDTH=8: MULTU 200*200 -> hi=0x9C, lo=0x40 after 8 busy cycles. SRL 0x80 by data_b=0x0F -> 0x01 (3-bit amount=7).
